// File: rtl/spq_pkg.sv
// spq_pkg: shared types and constants for the speech phone queue.
// Holds the playback state enum, the default phone/entry widths, the
// silence code, and the phase-accumulator increments for the supported
// system clocks (each gives a speech clock of about 720 kHz with a 16-bit
// accumulator).
package spq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    PLAY   = 2'd2
  } spq_state_t;

  localparam int SPQ_PHONE_W = 6;
  localparam int SPQ_ENTRY_W = SPQ_PHONE_W + 2;

  localparam logic [SPQ_PHONE_W-1:0] SPQ_STOP_PHONE = 6'h3F;

  localparam int SPQ_ACC_INC_48MHZ = 983;
  localparam int SPQ_ACC_INC_50MHZ = 944;

  // A queue entry is the phone code plus the two rate-select bits above it.
  function automatic int spq_entry_w(input int phone_w);
    return phone_w + 2;
  endfunction

endpackage

// File: rtl/spq_fifo.sv
// spq_fifo: circular FIFO with occupancy count.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   push, pop    write/read requests; callers never push when full unless
//                popping in the same clk, and never pop when empty
//   wdata        entry written on push
//   rdata        head entry (combinational from the read pointer)
//   level        number of stored entries, 0..DEPTH
//   full, empty  occupancy flags
module spq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        wdata,
  output logic [WIDTH-1:0]        rdata,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    full,
  output logic                    empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  // Storage has no reset: an entry is only visible once the pointers say so.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two. A push and pop
  // in the same clk move both pointers and leave the count alone; when full,
  // the pushed entry lands in the slot the pop is vacating.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign level = count;
  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/speech_phone_queue.sv
// speech_phone_queue: CPU phone queue and speech-chip clock generator.
// CPU writes are queued; a phase accumulator produces the one-clk ce_spk
// pulse, and the playback FSM presents one phone at a time to the speech
// core with a one-tick strobe followed by a rate-dependent duration.
// Ports:
//   clk, reset  system clock, synchronous active-high reset
//   sel_n, we   chip select (active low) and write enable from the CPU bus
//   din         [PHONE_W-1:0] phone code, [7:6] rate select
//   ce_spk      speech clock-enable pulse
//   phone, stb  phone code and strobe to the speech core
//   ar          ready: queue not full
//   busy        playing a phone or phones still queued
//   level       queue occupancy
//   ovf         sticky flag: a write arrived while the queue was full
module speech_phone_queue
  import spq_pkg::*;
#(
  parameter int                 DEPTH      = 4,
  parameter int                 PHONE_W    = SPQ_PHONE_W,
  parameter int                 INVERT     = 0,
  parameter int                 ACC_W      = 16,
  parameter int                 ACC_INC    = SPQ_ACC_INC_50MHZ,
  parameter int                 DUR_TICKS  = 2048,
  parameter logic [PHONE_W-1:0] STOP_PHONE = PHONE_W'(SPQ_STOP_PHONE)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sel_n,
  input  logic                   we,
  input  logic [7:0]             din,
  output logic                   ce_spk,
  output logic [PHONE_W-1:0]     phone,
  output logic                   stb,
  output logic                   ar,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   ovf
);

  localparam int ENT_W = spq_entry_w(PHONE_W);
  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int DUR_W = $clog2(DUR_TICKS + 1);

  logic [ACC_W-1:0]   acc;
  logic [ACC_W:0]     acc_sum;
  logic               wr;
  logic               wr_q;
  logic               push_req;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [PHONE_W-1:0] wr_phone;
  logic [ENT_W-1:0]   wr_entry;
  logic [ENT_W-1:0]   head;
  logic [1:0]         head_rate;
  logic [PHONE_W-1:0] head_phone;
  logic [DUR_W-1:0]   dur_load;

  spq_state_t         state;
  spq_state_t         state_d;
  logic [DUR_W-1:0]   dur;
  logic [DUR_W-1:0]   dur_d;
  logic [PHONE_W-1:0] phone_d;
  logic               stb_d;

  assign acc_sum = {1'b0, acc} + {1'b0, ACC_W'(ACC_INC)};

  // Fractional clock divider: ce_spk follows each accumulator carry-out by
  // one clk. With ACC_INC at most half the accumulator range a carry can
  // never occur on two consecutive clks, so the pulse is always isolated.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      ce_spk <= 1'b0;
    end else begin
      acc    <= acc_sum[ACC_W-1:0];
      ce_spk <= acc_sum[ACC_W];
    end
  end

  assign wr       = ~sel_n & we;
  assign push_req = wr & ~wr_q;
  assign wr_phone = (INVERT != 0) ? ~din[PHONE_W-1:0] : din[PHONE_W-1:0];
  assign wr_entry = {din[7:6], wr_phone};
  assign push     = push_req & (~fifo_full | pop);

  // Only the rising edge of the bus write queues an entry, so a CPU that
  // holds the write for several clks still produces one phone. A write that
  // finds the queue full (with no pop freeing a slot) is dropped and
  // latched in ovf until the next reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      wr_q <= wr;
      if (push_req & fifo_full & ~pop) begin
        ovf <= 1'b1;
      end
    end
  end

  spq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (head),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_rate  = head[ENT_W-1 -: 2];
  assign head_phone = head[PHONE_W-1:0];
  assign dur_load   = DUR_W'(DUR_TICKS) >> head_rate;

  // Playback state register. Reset abandons any phone in progress and puts
  // the silence code back on the speech core.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      dur   <= '0;
      phone <= STOP_PHONE;
      stb   <= 1'b0;
    end else begin
      state <= state_d;
      dur   <= dur_d;
      phone <= phone_d;
      stb   <= stb_d;
    end
  end

  // Playback sequencing, stepped only on speech ticks. A phone occupies one
  // strobe tick plus its duration; the PLAY countdown leaves on the tick
  // after dur has reached 1, and the next queued phone is fetched on the
  // following tick. phone holds its last value once the queue drains.
  always_comb begin
    state_d = state;
    dur_d   = dur;
    phone_d = phone;
    stb_d   = stb;
    pop     = 1'b0;
    if (ce_spk) begin
      unique case (state)
        IDLE: begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            phone_d = head_phone;
            dur_d   = dur_load;
            stb_d   = 1'b1;
            state_d = STROBE;
          end
        end
        STROBE: begin
          stb_d   = 1'b0;
          state_d = PLAY;
        end
        PLAY: begin
          if (dur <= DUR_W'(1)) begin
            state_d = IDLE;
          end else begin
            dur_d = dur - DUR_W'(1);
          end
        end
        default: begin
          stb_d   = 1'b0;
          state_d = IDLE;
        end
      endcase
    end
  end

  assign ar   = (level < LVL_W'(DEPTH));
  assign busy = (state != IDLE) | ~fifo_empty;

endmodule
